// File: rtl/mag_chan_pipe.sv
// Time-multiplexed per-channel front end: decimate, offset/gain correct, EMA drift track, slope.
// Three registered stages: decimated sample, corrected sample, drift/slope + output register.
module mag_chan_pipe #(
  parameter int ADC_BITS     = 10,
  parameter int W            = 24,
  parameter int FRAC         = 12,
  parameter int NCH          = 3,
  parameter int LOG2_OSR_MAX = 8,
  parameter int SLOPE_LOG2   = 10,
  localparam int CW          = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADC_BITS-1:0] adc_code,
  input  logic                adc_valid,
  input  logic [CW-1:0]       adc_ch,
  input  logic [7:0]          osr_log2,
  input  logic [NCH*W-1:0]    offset_flat,
  input  logic [NCH*W-1:0]    gain_flat,
  input  logic [4:0]          alpha_shift,
  input  logic [W-1:0]        freeze_th,
  input  logic                cfg_clear,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CW-1:0]       out_ch,
  output logic signed [W-1:0] out_data,
  output logic signed [W-1:0] out_drift,
  output logic                slope_valid,
  output logic [CW-1:0]       slope_ch,
  output logic [NCH*W-1:0]    slope_flat,
  output logic                ovf_sticky,
  output logic                drop_sticky
);
  localparam int AW   = W + LOG2_OSR_MAX;
  localparam int CNTW = LOG2_OSR_MAX + 1;
  localparam int SH   = FRAC - ADC_BITS + 1;

  // Returns {overflow, clamped W-bit value}; in range iff the bits from W-1 upward all match.
  function automatic logic [W:0] sat_w(input logic signed [2*W:0] v);
    logic [W+1:0] top;
    top = v[2*W:W-1];
    if ((&top) || (~|top)) sat_w = {1'b0, v[W-1:0]};
    else if (v[2*W])       sat_w = {1'b1, 1'b1, {(W-1){1'b0}}};
    else                   sat_w = {1'b1, 1'b0, {(W-1){1'b1}}};
  endfunction

  logic clr_s;
  assign clr_s = rst | cfg_clear;

  logic [7:0]           osr_r;
  logic signed [AW-1:0] acc_r [NCH];
  logic [CNTW-1:0]      cnt_r [NCH];
  logic                 d1_valid_r;
  logic [CW-1:0]        d1_ch_r;
  logic signed [W-1:0]  d1_dec_r;

  logic                   osr_chg_s, in_ok_s, last_s;
  logic [7:0]             l_s;
  logic [CW-1:0]          ch_s;
  logic signed [ADC_BITS:0] code_c_s;
  logic signed [W-1:0]    s_s;
  logic signed [AW-1:0]   acc_sum_s;
  logic [CNTW-1:0]        mask_s;

  // Centre and scale the ADC code and form this channel's running decimation sum.
  always_comb begin
    osr_chg_s = (osr_log2 != osr_r);
    if (osr_log2 > 8'(LOG2_OSR_MAX)) l_s = 8'(LOG2_OSR_MAX);
    else                             l_s = osr_log2;
    if ({1'b0, adc_ch} < (CW+1)'(NCH)) begin
      in_ok_s = adc_valid & ~osr_chg_s;
      ch_s    = adc_ch;
    end else begin
      in_ok_s = 1'b0;
      ch_s    = {CW{1'b0}};
    end
    code_c_s  = $signed({1'b0, adc_code}) - $signed({2'b01, {(ADC_BITS-1){1'b0}}});
    s_s       = W'(code_c_s) <<< SH;
    acc_sum_s = acc_r[ch_s] + AW'(s_s);
    mask_s    = (CNTW'(1) << l_s) - CNTW'(1);
    last_s    = (cnt_r[ch_s] == mask_s);
  end

  // OSR tracking, per-channel accumulators and the decimated-sample register.
  always_ff @(posedge clk) begin
    if (clr_s) begin
      osr_r      <= 8'd0;
      d1_valid_r <= 1'b0;
      d1_ch_r    <= {CW{1'b0}};
      d1_dec_r   <= {W{1'b0}};
      for (int i = 0; i < NCH; i++) begin
        acc_r[i] <= {AW{1'b0}};
        cnt_r[i] <= {CNTW{1'b0}};
      end
    end else if (osr_chg_s) begin
      // A ratio change abandons every partial window, including this cycle's sample.
      osr_r      <= osr_log2;
      d1_valid_r <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        acc_r[i] <= {AW{1'b0}};
        cnt_r[i] <= {CNTW{1'b0}};
      end
    end else begin
      d1_valid_r <= in_ok_s & last_s;
      d1_ch_r    <= ch_s;
      d1_dec_r   <= W'(acc_sum_s >>> l_s);
      if (in_ok_s) begin
        if (last_s) begin
          acc_r[ch_s] <= {AW{1'b0}};
          cnt_r[ch_s] <= {CNTW{1'b0}};
        end else begin
          acc_r[ch_s] <= acc_sum_s;
          cnt_r[ch_s] <= cnt_r[ch_s] + CNTW'(1);
        end
      end
    end
  end

  logic signed [W-1:0] off_s, gain_s;
  logic signed [W:0]   diff_s;
  logic signed [2*W:0] prod_s;
  logic [W:0]          ysat_s;

  // Offset/gain correction at full product width, then saturate to W bits.
  always_comb begin
    off_s  = offset_flat[d1_ch_r*W +: W];
    gain_s = gain_flat[d1_ch_r*W +: W];
    diff_s = (W+1)'(d1_dec_r) - (W+1)'(off_s);
    prod_s = (2*W+1)'(diff_s) * (2*W+1)'(gain_s);
    ysat_s = sat_w(prod_s >>> FRAC);
  end

  logic                y_valid_r, y_ovf_r;
  logic [CW-1:0]       y_ch_r;
  logic signed [W-1:0] y_r;

  // Corrected-sample register.
  always_ff @(posedge clk) begin
    if (clr_s) begin
      y_valid_r <= 1'b0;
      y_ovf_r   <= 1'b0;
      y_ch_r    <= {CW{1'b0}};
      y_r       <= {W{1'b0}};
    end else begin
      y_valid_r <= d1_valid_r;
      y_ovf_r   <= d1_valid_r & ysat_s[W];
      y_ch_r    <= d1_ch_r;
      y_r       <= ysat_s[W-1:0];
    end
  end

  logic signed [W-1:0]   drift_r [NCH];
  logic signed [W-1:0]   prev_r  [NCH];
  logic [SLOPE_LOG2-1:0] scnt_r  [NCH];
  logic signed [W-1:0]   drift_cur_s, drift_new_s, slope_s;
  logic signed [W:0]     e_s, step_s, sum_s;
  logic [W:0]            abs_e_s, esat_s;
  logic                  upd_s, hit_s;

  // Drift error, freeze decision, EMA step and slope window arithmetic for the current channel.
  always_comb begin
    drift_cur_s = drift_r[y_ch_r];
    e_s         = (W+1)'(y_r) - (W+1)'(drift_cur_s);
    if (e_s[W]) abs_e_s = -e_s;
    else        abs_e_s = e_s;
    upd_s  = (freeze_th == {W{1'b0}}) || (abs_e_s <= {1'b0, freeze_th});
    step_s = e_s >>> alpha_shift;
    sum_s  = (W+1)'(drift_cur_s) + step_s;
    if (upd_s) drift_new_s = W'(sum_s);
    else       drift_new_s = drift_cur_s;
    esat_s  = sat_w((2*W+1)'(e_s));
    hit_s   = &scnt_r[y_ch_r];
    slope_s = drift_new_s - prev_r[y_ch_r];
  end

  // Drift/slope state and the single-entry output register with backpressure.
  always_ff @(posedge clk) begin
    if (clr_s) begin
      out_valid   <= 1'b0;
      out_ch      <= {CW{1'b0}};
      out_data    <= {W{1'b0}};
      out_drift   <= {W{1'b0}};
      slope_valid <= 1'b0;
      slope_ch    <= {CW{1'b0}};
      slope_flat  <= {(NCH*W){1'b0}};
      ovf_sticky  <= 1'b0;
      drop_sticky <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        drift_r[i] <= {W{1'b0}};
        prev_r[i]  <= {W{1'b0}};
        scnt_r[i]  <= {SLOPE_LOG2{1'b0}};
      end
    end else begin
      slope_valid <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (y_valid_r) begin
        drift_r[y_ch_r] <= drift_new_s;
        scnt_r[y_ch_r]  <= scnt_r[y_ch_r] + SLOPE_LOG2'(1);
        if (hit_s) begin
          prev_r[y_ch_r]              <= drift_new_s;
          slope_flat[y_ch_r*W +: W]   <= slope_s;
          slope_valid                 <= 1'b1;
          slope_ch                    <= y_ch_r;
        end
        if (!out_valid || out_ready) begin
          out_valid <= 1'b1;
          out_ch    <= y_ch_r;
          out_data  <= esat_s[W-1:0];
          out_drift <= drift_new_s;
        end else begin
          drop_sticky <= 1'b1;
        end
        if (y_ovf_r || esat_s[W]) ovf_sticky <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mag_chan_pipe.sv
// Bench for mag_chan_pipe: arithmetic reference model with per-cycle compare plus directed literal checks.
module tb_mag_chan_pipe;
  localparam int W   = 24;
  localparam int NCH = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, adc_valid, cfg_clear, out_ready;
  logic [9:0]        adc_code;
  logic [1:0]        adc_ch;
  logic [7:0]        osr_log2;
  logic [NCH*W-1:0]  offset_flat, gain_flat;
  logic [4:0]        alpha_shift;
  logic [W-1:0]      freeze_th;
  logic              out_valid, slope_valid, ovf_sticky, drop_sticky;
  logic [1:0]        out_ch, slope_ch;
  logic signed [W-1:0] out_data, out_drift;
  logic [NCH*W-1:0]  slope_flat;

  mag_chan_pipe #(.SLOPE_LOG2(2)) dut (
    .clk(clk), .rst(rst), .adc_code(adc_code), .adc_valid(adc_valid), .adc_ch(adc_ch),
    .osr_log2(osr_log2), .offset_flat(offset_flat), .gain_flat(gain_flat),
    .alpha_shift(alpha_shift), .freeze_th(freeze_th), .cfg_clear(cfg_clear),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .out_data(out_data),
    .out_drift(out_drift), .slope_valid(slope_valid), .slope_ch(slope_ch),
    .slope_flat(slope_flat), .ovf_sticky(ovf_sticky), .drop_sticky(drop_sticky)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int     due;
    int     ch;
    longint data;
    longint drift;
    bit     sv;
    longint slope;
    bit     ovf;
  } res_t;

  res_t   pend[$];
  longint m_sum[NCH], m_drift[NCH], m_prev[NCH], m_slope[NCH];
  int     m_cnt[NCH], m_scnt[NCH];
  int     m_osr = 0, cyc = 0;
  bit     mv = 0, msv = 0, movf = 0, mdrop = 0, prev_mv;
  int     mch = 0, msch = 0;
  longint mdata = 0, mdrift = 0;
  res_t   r;

  function automatic longint clampw(input longint v);
    if (v > 64'sd8388607) return 64'sd8388607;
    else if (v < -64'sd8388608) return -64'sd8388608;
    else return v;
  endfunction

  function automatic bit oorw(input longint v);
    return (v > 64'sd8388607) || (v < -64'sd8388608);
  endfunction

  function automatic longint wrapw(input longint v);
    logic signed [W-1:0] t;
    t = W'(v);
    return longint'(t);
  endfunction

  task automatic model_sample(input int c, input int code);
    longint s, dec, off, gn, p, y, e, ae, sl;
    int L;
    bit ov, sv;
    res_t n;
    s = (longint'(code) - 512) * 8;
    L = (m_osr > 8) ? 8 : m_osr;
    m_sum[c] += s;
    m_cnt[c]++;
    if (m_cnt[c] == (1 << L)) begin
      dec = m_sum[c] >>> L;
      m_sum[c] = 0;
      m_cnt[c] = 0;
      off = longint'($signed(offset_flat[c*W +: W]));
      gn  = longint'($signed(gain_flat[c*W +: W]));
      p   = ((dec - off) * gn) >>> 12;
      ov  = oorw(p);
      y   = clampw(p);
      e   = y - m_drift[c];
      ae  = (e < 0) ? -e : e;
      if (freeze_th == 0 || ae <= longint'(freeze_th)) m_drift[c] += e >>> alpha_shift;
      ov  = ov | oorw(e);
      sv  = 0;
      sl  = 0;
      m_scnt[c]++;
      if (m_scnt[c] == 4) begin
        sv = 1;
        sl = wrapw(m_drift[c] - m_prev[c]);
        m_prev[c] = m_drift[c];
        m_scnt[c] = 0;
      end
      n.due = cyc + 2; n.ch = c; n.data = clampw(e); n.drift = m_drift[c];
      n.sv = sv; n.slope = sl; n.ovf = ov;
      pend.push_back(n);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (rst || cfg_clear) begin
      pend.delete();
      for (int c = 0; c < NCH; c++) begin
        m_sum[c] = 0; m_cnt[c] = 0; m_drift[c] = 0; m_prev[c] = 0; m_slope[c] = 0; m_scnt[c] = 0;
      end
      m_osr = 0; mv = 0; msv = 0; movf = 0; mdrop = 0; mch = 0; msch = 0; mdata = 0; mdrift = 0;
    end else begin
      prev_mv = mv;
      msv = 0;
      if (mv && out_ready) mv = 0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        r = pend.pop_front();
        if (!prev_mv || out_ready) begin
          mv = 1; mch = r.ch; mdata = r.data; mdrift = r.drift;
        end else begin
          mdrop = 1;
        end
        if (r.sv) begin
          msv = 1; msch = r.ch; m_slope[r.ch] = r.slope;
        end
        if (r.ovf) movf = 1;
      end
      if (int'(osr_log2) != m_osr) begin
        m_osr = int'(osr_log2);
        for (int c = 0; c < NCH; c++) begin
          m_sum[c] = 0; m_cnt[c] = 0;
        end
      end else if (adc_valid && int'(adc_ch) < NCH) begin
        model_sample(int'(adc_ch), int'(adc_code));
      end
    end
  end

  // per-cycle compare against the model, just after each active edge
  always @(posedge clk) begin
    #1;
    chk("out_valid", out_valid, mv);
    if (mv) begin
      chk("out_ch", out_ch, mch);
      chk("out_data", out_data, mdata);
      chk("out_drift", out_drift, mdrift);
    end
    chk("slope_valid", slope_valid, msv);
    if (msv) chk("slope_ch", slope_ch, msch);
    for (int c = 0; c < NCH; c++)
      chk("slope_flat", longint'($signed(slope_flat[c*W +: W])), m_slope[c]);
    chk("ovf_sticky", ovf_sticky, movf);
    chk("drop_sticky", drop_sticky, mdrop);
  end

  // ---------------- directed stimulus ----------------
  task automatic drive(input bit v, input int ch, input int code);
    @(negedge clk);
    adc_valid = v;
    adc_ch    = 2'(ch);
    adc_code  = 10'(code);
  endtask

  task automatic send(input int ch, input int code);
    drive(1'b1, ch, code);
    drive(1'b0, 0, 512);
  endtask

  // result of the sample just sent: absent at t+2, present at t+3
  task automatic expect_out(input string nm, input int ch, input longint data, input longint drift);
    @(negedge clk);
    chk({nm, "_early"}, out_valid, 0);
    @(negedge clk);
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_ch"}, out_ch, ch);
    chk({nm, "_data"}, out_data, data);
    chk({nm, "_drift"}, out_drift, drift);
  endtask

  task automatic expect_zero(input string nm);
    chk({nm, "_valid"}, out_valid, 0);
    chk({nm, "_data"}, out_data, 0);
    chk({nm, "_drift"}, out_drift, 0);
    chk({nm, "_slope_valid"}, slope_valid, 0);
    chk({nm, "_slope_flat"}, (slope_flat == '0) ? 1 : 0, 1);
    chk({nm, "_ovf"}, ovf_sticky, 0);
    chk({nm, "_drop"}, drop_sticky, 0);
  endtask

  task automatic soft_clear();
    @(negedge clk);
    cfg_clear = 1'b1;
    @(negedge clk);
    cfg_clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cfg_clear = 1'b0; adc_valid = 1'b0; adc_ch = 2'd0; adc_code = 10'd512;
    osr_log2 = 8'd0; offset_flat = '0; gain_flat = {3{24'sd4096}};
    alpha_shift = 5'd4; freeze_th = 24'd0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    expect_zero("reset");
    rst = 1'b0;

    // passthrough + EMA
    send(0, 612);  expect_out("pass1", 0, 800, 50);
    send(0, 612);  expect_out("pass2", 0, 750, 96);
    send(3, 900);  repeat (3) @(negedge clk);
    chk("bad_ch_ignored", out_valid, 0);

    // OSR = 4, interleaved channels; only ch1 completes
    osr_log2 = 8'd2;
    drive(1, 0, 600); drive(1, 1, 520); drive(1, 2, 700); drive(1, 1, 528);
    drive(1, 0, 600); drive(1, 1, 536); drive(1, 2, 700); drive(1, 1, 544);
    drive(0, 0, 512);
    expect_out("osr4", 1, 160, 10);

    // ratio change mid-window, with a sample in the change cycle
    drive(1, 1, 520); drive(1, 1, 528);
    @(negedge clk);
    osr_log2 = 8'd1; adc_valid = 1'b1; adc_ch = 2'd1; adc_code = 10'd1000;
    drive(0, 0, 512);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("osr_change_no_partial", out_valid, 0);
    end
    drive(1, 1, 520); drive(1, 1, 528); drive(0, 0, 512);
    expect_out("osr2", 1, 86, 15);
    osr_log2 = 8'd0;
    @(negedge clk);

    // saturation
    soft_clear();
    expect_zero("clear");
    gain_flat[23:0] = 24'h7FFFFF;
    offset_flat[23:0] = -24'sd100;
    send(0, 1023); expect_out("sat_hi", 0, 8388607, 524287);
    chk("sat_ovf", ovf_sticky, 1);
    send(0, 0);
    repeat (2) @(negedge clk);
    chk("sat_lo_data", out_data, -8388608);
    gain_flat[23:0] = 24'sd4096;
    offset_flat[23:0] = 24'sd0;

    // freeze
    soft_clear();
    freeze_th = 24'd100;
    send(0, 612);  expect_out("frz_hold", 0, 800, 0);
    send(0, 520);  expect_out("frz_upd", 0, 64, 4);
    freeze_th = 24'd0;

    // backpressure
    soft_clear();
    out_ready = 1'b0;
    send(0, 612);  expect_out("bp_a", 0, 800, 50);
    send(0, 612);  repeat (2) @(negedge clk);
    chk("bp_held_data", out_data, 800);
    chk("bp_held_drift", out_drift, 50);
    chk("bp_drop", drop_sticky, 1);
    send(0, 612);
    @(negedge clk);
    chk("bp_still_a", out_data, 800);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_c_valid", out_valid, 1);
    chk("bp_c_data", out_data, 704);
    chk("bp_c_drift", out_drift, 140);

    // slope window of 4, then reset mid-stream
    soft_clear();
    alpha_shift = 5'd1;
    send(0, 612); send(0, 612); send(0, 612);
    send(0, 612);  expect_out("slope4", 0, 100, 750);
    chk("slope_pulse", slope_valid, 1);
    chk("slope_ch0", slope_ch, 0);
    chk("slope_val", longint'($signed(slope_flat[23:0])), 750);
    drive(1, 0, 612);
    @(negedge clk);
    adc_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    expect_zero("rst_mid");
    @(negedge clk);
    rst = 1'b1; adc_valid = 1'b1; adc_ch = 2'd0; adc_code = 10'd612;
    @(negedge clk);
    rst = 1'b0; adc_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_sample_ignored", out_valid, 0);
    send(0, 612);  expect_out("after_rst", 0, 800, 400);

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
